fifo_write_arbiter: RTL

//   Shares the single write port of one asyncfifo instance between NUM_REQ

---
 rtl/fifo_write_arbiter.sv | 82 ++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: rotating-priority, packet-atomic arbiter sharing one FIFO write port
// with a stall watchdog that revokes a grant whose owner goes silent mid-packet.
module fifo_write_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int STALL_LIMIT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          stall_error,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    input  logic                          fifo_can_write
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          state;
    logic [PW-1:0]   rr_ptr, owner, pick, idx, next_ptr;
    logic [7:0]      stall_cnt;
    logic            found, in_burst;
    always_comb begin
        pick  = rr_ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
    // Priority rotates past the owner whenever its grant ends, wrapping at NUM_REQ.
    assign next_ptr        = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign in_burst        = (state == BURST) && !reset;
    assign busy            = (state == BURST);
    assign fifo_write      = in_burst && req[owner] && fifo_can_write;
    assign fifo_write_data = in_burst ? req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign ack             = fifo_write ? grant : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            stall_cnt   <= '0;
            stall_error <= 1'b0;
        end else if (state == IDLE) begin
            if (|req) begin
                state     <= BURST;
                owner     <= pick;
                grant     <= NUM_REQ'(1) << pick;
                stall_cnt <= '0;
            end
        end else if (fifo_write) begin
            stall_cnt <= '0;
            if (req_last[owner]) begin
                state  <= IDLE;
                grant  <= '0;
                rr_ptr <= next_ptr;
            end
        end else if (!req[owner]) begin
            // The STALL_LIMIT-th consecutive silent cycle revokes the grant.
            if (stall_cnt == 8'(STALL_LIMIT - 1)) begin
                state       <= IDLE;
                grant       <= '0;
                rr_ptr      <= next_ptr;
                stall_error <= 1'b1;
            end else begin
                stall_cnt <= stall_cnt + 8'd1;
            end
        end else begin
            stall_cnt <= '0;
        end
    end
endmodule
